// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the instruction encoder and the control decoder:
//   - 4-bit internal op codes 0-9 (10-15 are illegal)
//   - MIPS primary opcode and R-format funct constants
//   - FSM state encoding of the program loader
//   - helpers that pack R-format and I-format instruction words
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

    localparam int OP_W = 4;

    // Internal op codes
    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLT = 4'd4;
    localparam logic [OP_W-1:0] OP_LW  = 4'd5;
    localparam logic [OP_W-1:0] OP_SW  = 4'd6;
    localparam logic [OP_W-1:0] OP_BEQ = 4'd7;
    localparam logic [OP_W-1:0] OP_ORI = 4'd8;
    localparam logic [OP_W-1:0] OP_LUI = 4'd9;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    // MIPS R-format funct field
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Program-loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // R-format: opcode 0, shamt 0
    function automatic logic [31:0] r_word(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    // I-format: {opcode, rs, rt, imm}
    function automatic logic [31:0] i_word(input logic [5:0]  opc,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_enc.sv
// ----------------------------------------------------------------------------
// instr_word_enc
// Purely combinational translation of one internal op into a 32-bit MIPS
// instruction word.
// Ports:
//   op            in  4   internal op code
//   rs, rt, rd    in  5   register fields
//   imm           in  16  immediate
//   word          out 32  encoded instruction (0 for illegal ops)
//   legal         out 1   1 when op is 0-9
// ----------------------------------------------------------------------------
module instr_word_enc
    import instr_encoder_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [15:0]     imm,
    output logic [31:0]     word,
    output logic            legal
);

    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = r_word(rs, rt, rd, FN_ADD);
            OP_SUB:  word = r_word(rs, rt, rd, FN_SUB);
            OP_AND:  word = r_word(rs, rt, rd, FN_AND);
            OP_OR:   word = r_word(rs, rt, rd, FN_OR);
            OP_SLT:  word = r_word(rs, rt, rd, FN_SLT);
            OP_LW:   word = i_word(OPC_LW,  rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW,  rs, rt, imm);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            // LUI has no source register; whatever sits on rs is dropped
            OP_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Streams ops into instruction memory as encoded MIPS words. A start in IDLE
// loads the write pointer; each accepted op is encoded and placed in a
// one-deep output register that drives the memory write request until it is
// granted. The last op moves the FSM to DRAIN, then DONE pulses done.
// Ports:
//   clock, reset_n          clock / asynchronous active-low reset
//   start, base_addr        begin program load at word address base_addr
//   in_valid/in_ready       op handshake; in_last marks the final op
//   in_op, in_rs, in_rt,
//   in_rd, in_imm           op and its fields
//   mem_req/mem_gnt         imem write handshake
//   mem_addr, mem_wdata     imem write address / data
//   busy, done, err, count  status: loading, end pulse, sticky illegal op,
//                           words written (saturating)
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [OP_W-1:0]   in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       count
);

    state_e            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [31:0]       wdata_reg;
    logic              req_reg;
    logic              err_reg;
    logic [15:0]       count_reg;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              write_done;

    instr_word_enc u_enc (
        .op    (in_op),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .imm   (in_imm),
        .word  (enc_word),
        .legal (enc_legal)
    );

    // The output register can take a new word when it is empty or when its
    // current word retires on this very edge.
    assign in_ready   = (state_reg == ST_STREAM) && (!req_reg || mem_gnt);
    assign accept     = in_valid && in_ready;
    // A grant only counts while a request is outstanding
    assign write_done = req_reg && mem_gnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            wdata_reg <= 32'd0;
            req_reg   <= 1'b0;
            err_reg   <= 1'b0;
            count_reg <= 16'd0;
        end else begin
            // The pointer always names the address of the word in (or next
            // to enter) the output register, so it only moves on retirement.
            if (write_done) begin
                ptr_reg <= ptr_reg + ADDR_W'(4);
                if (count_reg != 16'hFFFF)
                    count_reg <= count_reg + 16'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ptr_reg   <= base_addr;
                        count_reg <= 16'd0;
                        err_reg   <= 1'b0;
                        req_reg   <= 1'b0;
                        state_reg <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept && enc_legal) begin
                        req_reg   <= 1'b1;
                        wdata_reg <= enc_word;
                    end else begin
                        // Illegal ops are swallowed: nothing new is loaded
                        req_reg <= req_reg && !mem_gnt;
                        if (accept)
                            err_reg <= 1'b1;
                    end
                    if (accept && in_last)
                        state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!req_reg || mem_gnt) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = req_reg;
    assign mem_addr  = ptr_reg;
    assign mem_wdata = wdata_reg;
    assign err       = err_reg;
    assign count     = count_reg;
    assign busy      = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. Expected {addr, word} pairs are
// queued when an op is accepted and compared when the DUT completes a write.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    int          checks;
    int          errors;
    logic [63:0] sb_q[$];
    logic [31:0] exp_ptr;

    instr_encoder #(.ADDR_W(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write monitor: a write completes at the posedge following a negedge
    // where mem_req & mem_gnt (inputs only change just after posedges).
    always @(negedge clock) begin
        logic [63:0] exp_e;
        if (reset_n && mem_req && mem_gnt) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required no write", mem_addr, mem_wdata);
            end else begin
                exp_e = sb_q.pop_front();
                if (mem_addr !== exp_e[63:32] || mem_wdata !== exp_e[31:0]) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             mem_addr, mem_wdata, exp_e[63:32], exp_e[31:0]);
                end else begin
                    $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
                end
            end
        end
    end

    // ---------------- drive helpers (return at posedge+1) ----------------
    task automatic do_start(input logic [31:0] b);
        start     = 1'b1;
        base_addr = b;
        exp_ptr   = b;
        @(posedge clock); #1;
        start     = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm, input logic last,
                           input logic push, input logic [31:0] exp_word);
        logic acc;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b required 1", op, in_ready);
        end else if (push) begin
            sb_q.push_back({exp_ptr, exp_word});
            exp_ptr = exp_ptr + 32'd4;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done busy=%b required 0", busy);
                end
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout done=%b required 1", done);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_width done=%b busy=%b required 0 0", done, busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover pending=%0d required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        checks++;
        if ({mem_req, in_ready, busy, done, err} !== 5'b0 || count !== 16'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs req=%b rdy=%b busy=%b done=%b err=%b cnt=%h addr=%h data=%h required all 0",
                     mem_req, in_ready, busy, done, err, count, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset rdy=%b busy=%b required 0 0", in_ready, busy);
        end
        @(posedge clock); #1;
        $display("test_reset done");
    endtask

    task automatic test_add();
        mem_gnt = 1'b1;
        do_start(32'h0040_0000);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b1, 32'h0022_1820);
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h0022_1820) begin
            errors++;
            $display("FAIL add_latency req=%b addr=%h data=%h required 1 00400000 00221820",
                     mem_req, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        wait_done();
        checks++;
        if (count !== 16'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_count count=%0d err=%b required 1 0", count, err);
        end
        check_empty("add");
        $display("test_add done");
    endtask

    task automatic test_lw_sw();
        mem_gnt = 1'b1;
        do_start(32'h0000_1000);
        send_op(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b1, 32'h8FA8_0004);
        send_op(4'd6, 5'd29, 5'd8, 5'd0, 16'h0008, 1'b1, 1'b1, 32'hAFA8_0008);
        wait_done();
        checks++;
        if (count !== 16'd2 || mem_addr !== 32'h0000_1008) begin
            errors++;
            $display("FAIL lwsw_count count=%0d ptr=%h required 2 00001008", count, mem_addr);
        end
        check_empty("lwsw");
        $display("test_lw_sw done");
    endtask

    task automatic test_iformat();
        mem_gnt = 1'b1;
        do_start(32'h0000_2000);
        send_op(4'd9, 5'd7, 5'd1, 5'd0, 16'h1234, 1'b0, 1'b1, 32'h3C01_1234);
        send_op(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b0, 1'b1, 32'h1022_FFFF);
        send_op(4'd8, 5'd0, 5'd2, 5'd0, 16'h00FF, 1'b1, 1'b1, 32'h3402_00FF);
        wait_done();
        checks++;
        if (count !== 16'd3) begin
            errors++;
            $display("FAIL iformat_count count=%0d required 3", count);
        end
        check_empty("iformat");
        $display("test_iformat done");
    endtask

    task automatic test_stall();
        logic [31:0] a0, d0;
        mem_gnt = 1'b0;
        do_start(32'h0000_3000);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'h0022_1820);
        // Offer the next op while the grant is withheld
        in_op = 4'd1; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_valid = 1'b1;
        a0 = 32'h0000_3000;
        d0 = 32'h0022_1820;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d req=%b addr=%h data=%h rdy=%b required 1 %h %h 0",
                         i, mem_req, mem_addr, mem_wdata, in_ready, a0, d0);
            end
            @(posedge clock); #1;
        end
        mem_gnt = 1'b1;
        send_op(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1, 1'b1, 32'h0085_3022);
        wait_done();
        checks++;
        if (count !== 16'd2) begin
            errors++;
            $display("FAIL stall_count count=%0d required 2", count);
        end
        check_empty("stall");
        $display("test_stall done");
    endtask

    task automatic test_illegal();
        mem_gnt = 1'b1;
        do_start(32'h0000_4000);
        send_op(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 1'b0, 32'h0);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b1, 32'h0022_1820);
        wait_done();
        checks++;
        if (err !== 1'b1 || count !== 16'd1) begin
            errors++;
            $display("FAIL illegal_mid err=%b count=%0d required 1 1", err, count);
        end
        check_empty("illegal");
        // Illegal final op: nothing written, the run still finishes
        do_start(32'h0000_5000);
        send_op(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 32'h0);
        wait_done();
        checks++;
        if (err !== 1'b1 || count !== 16'd0 || mem_addr !== 32'h0000_5000) begin
            errors++;
            $display("FAIL illegal_last err=%b count=%0d ptr=%h required 1 0 00005000", err, count, mem_addr);
        end
        check_empty("illegal_last");
        $display("test_illegal done");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [31:0] words [4];
        ops   = '{4'd1, 4'd2, 4'd3, 4'd4};
        words = '{32'h0085_3022, 32'h00E8_4824, 32'h014B_6025, 32'h01AE_782A};
        mem_gnt = 1'b1;
        do_start(32'h0000_6000);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err err=%b required 0", err);
        end
        for (int i = 0; i < 4; i++) begin
            in_op   = ops[i];
            in_rs   = 5'(4 + 3 * i);
            in_rt   = 5'(5 + 3 * i);
            in_rd   = 5'(6 + 3 * i);
            in_imm  = 16'h0;
            in_last = (i == 3);
            in_valid = 1'b1;
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b1 || (i > 0 && mem_req !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_bubble i=%0d rdy=%b req=%b required 1 1", i, in_ready, mem_req);
            end
            sb_q.push_back({exp_ptr, words[i]});
            exp_ptr = exp_ptr + 32'd4;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done();
        checks++;
        if (count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_count count=%0d required 4", count);
        end
        check_empty("b2b");
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        mem_gnt = 1'b1;
        do_start(32'hFFFF_FFFC);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'h0022_1820);
        send_op(4'd6, 5'd29, 5'd8, 5'd0, 16'h0008, 1'b1, 1'b1, 32'hAFA8_0008);
        wait_done();
        checks++;
        if (count !== 16'd2 || mem_addr !== 32'h0000_0004) begin
            errors++;
            $display("FAIL wrap_ptr count=%0d ptr=%h required 2 00000004", count, mem_addr);
        end
        check_empty("wrap");
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        mem_gnt = 1'b0;
        do_start(32'h0000_7000);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req req=%b required 1", mem_req);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, in_ready, busy, done, err} !== 5'b0 || count !== 16'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid req=%b rdy=%b busy=%b done=%b err=%b cnt=%h addr=%h data=%h required all 0",
                     mem_req, in_ready, busy, done, err, count, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        reset_n  = 1'b1;
        mem_gnt  = 1'b1;
        in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_start_after_reset cyc=%0d rdy=%b req=%b busy=%b required 0 0 0",
                         i, in_ready, mem_req, busy);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        do_start(32'h0000_7000);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b1, 32'h0022_1820);
        wait_done();
        checks++;
        if (count !== 16'd1) begin
            errors++;
            $display("FAIL restart_count count=%0d required 1", count);
        end
        check_empty("reset_mid");
        $display("test_reset_mid done");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; exp_ptr = 32'd0;
        reset_n = 1'b0; start = 1'b0; base_addr = 32'd0;
        in_valid = 1'b0; in_last = 1'b0; in_op = 4'd0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0;
        mem_gnt = 1'b0;
        test_reset();
        test_add();
        test_lw_sw();
        test_iformat();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
